// File: rtl/memory_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter: word size, FSM states and owner tags.
package memory_port_arbiter_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/memory_port_arbiter_mem_latency_counter.sv
// Down-counter that times one memory access; flags zero on the last access cycle.
module memory_port_arbiter_mem_latency_counter #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/memory_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access, data-first
// with a burst guard that forces a fetch grant after D_BURST back-to-back data grants.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int D_BURST = 4,
  parameter int WORD    = WORD_SIZE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [WORD-1:0] i_addr,
  output logic [WORD-1:0] i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [WORD-1:0] d_addr,
  input  logic [WORD-1:0] d_wdata,
  output logic [WORD-1:0] d_rdata,
  output logic            d_done,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            busy
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BW = $clog2(D_BURST + 1);
  localparam logic [CW-1:0] LAT_LOAD  = CW'(MEM_LAT - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(D_BURST);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [WORD-1:0] addr_q, addr_d;
  logic [WORD-1:0] wdata_q, wdata_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            we_q, we_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            grant;
  logic            in_access;
  logic            wait_zero;
  logic            in_done;

  assign in_access = (state_q == ARB_ACCESS);
  assign in_done   = (state_q == ARB_DONE);

  memory_port_arbiter_mem_latency_counter #(
    .CW (CW)
  ) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (grant),
    .load_val_i (LAT_LOAD),
    .en_i       (in_access),
    .zero_o     (wait_zero)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    burst_d = burst_q;
    grant   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          state_d = ARB_ACCESS;
          // Data wins unless a fetch has waited through a full burst of data grants.
          if (d_req && (!i_req || (burst_q != BURST_MAX))) begin
            owner_d = OWN_D;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
            burst_d = i_req ? (burst_q + BW'(1)) : '0;
          end else begin
            owner_d = OWN_I;
            addr_d  = i_addr;
            wdata_d = '0;
            we_d    = 1'b0;
            burst_d = '0;
          end
        end
      end
      ARB_ACCESS: begin
        if (wait_zero) begin
          rdata_d = mem_rdata;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      burst_q <= burst_d;
    end
  end

  assign busy      = (state_q != ARB_IDLE);
  assign mem_read  = in_access & ~we_q;
  assign mem_write = in_access & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_done    = in_done & (owner_q == OWN_I);
  assign d_done    = in_done & (owner_q == OWN_D);
  assign i_rdata   = i_done ? rdata_q : '0;
  assign d_rdata   = d_done ? rdata_q : '0;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench: per-cycle transaction-timing model plus directed literal checks.
module tb_memory_port_arbiter;

  localparam int MEM_LAT = 2;
  localparam int D_BURST = 4;
  localparam int WORD    = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_req = 1'b0;
  logic [WORD-1:0] i_addr = '0;
  logic [WORD-1:0] i_rdata;
  logic            i_done;
  logic            d_req = 1'b0;
  logic            d_we = 1'b0;
  logic [WORD-1:0] d_addr = '0;
  logic [WORD-1:0] d_wdata = '0;
  logic [WORD-1:0] d_rdata;
  logic            d_done;
  logic            mem_read;
  logic            mem_write;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory_port_arbiter #(
    .MEM_LAT (MEM_LAT),
    .D_BURST (D_BURST),
    .WORD    (WORD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Read-only memory image: one pinned word, everything else a simple address hash.
  function automatic logic [WORD-1:0] mem_fn(input logic [WORD-1:0] a);
    return (a == 16'h0010) ? 16'hABCD : (a ^ 16'h5A5A);
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a transaction occupies MEM_LAT+2 cycles from its grant; age counts cycles since grant.
  int              m_age = 0;
  int              m_burst = 0;
  bit              m_own_d = 1'b0;
  bit              m_we = 1'b0;
  logic [WORD-1:0] m_addr = '0;
  logic [WORD-1:0] m_wdata = '0;
  logic [WORD-1:0] m_rdata = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_age   = 0;
        m_burst = 0;
        m_we    = 1'b0;
      end
      chk("busy", busy, (m_age != 0));
      chk("mem_read", mem_read, (m_age >= 1 && m_age <= MEM_LAT && !m_we));
      chk("mem_write", mem_write, (m_age >= 1 && m_age <= MEM_LAT && m_we));
      chk("i_done", i_done, (m_age == MEM_LAT + 1 && !m_own_d));
      chk("d_done", d_done, (m_age == MEM_LAT + 1 && m_own_d));
      if (m_age >= 1 && m_age <= MEM_LAT) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      if (m_age == MEM_LAT + 1 && !m_we) begin
        if (m_own_d) chk("d_rdata", d_rdata, m_rdata);
        else         chk("i_rdata", i_rdata, m_rdata);
      end
      if (!reset) begin
        if (m_age == 0) begin
          if (i_req || d_req) begin
            m_own_d = d_req && (!i_req || m_burst < D_BURST);
            if (m_own_d) begin
              m_addr  = d_addr;
              m_wdata = d_wdata;
              m_we    = d_we;
              m_burst = i_req ? ((m_burst < D_BURST) ? m_burst + 1 : D_BURST) : 0;
            end else begin
              m_addr  = i_addr;
              m_we    = 1'b0;
              m_burst = 0;
            end
            m_age = 1;
          end
        end else if (m_age == MEM_LAT + 1) begin
          m_age = 0;
        end else begin
          if (m_age == MEM_LAT) m_rdata = mem_fn(m_addr);
          m_age++;
        end
      end
    end
  end

  task automatic wait_done(input string nm, output bit was_d);
    int n;
    n = 0;
    while (!(i_done || d_done) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      n_fail++;
      n_tests++;
      $display("FAIL %s: no done within 20 cycles", nm);
    end
    was_d = d_done;
  endtask

  bit own;
  bit owners[10];
  bit exp_owners[10];
  int rd_cnt;
  int idone_cnt;
  int lat;

  initial begin
    exp_owners = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_done", i_done, 0);
    chk("rst_d_done", d_done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Lone fetch
    i_req = 1'b1; i_addr = 16'h0010;
    step();
    chk("t1_read_c1", mem_read, 1);
    chk("t1_addr_c1", mem_addr, 16'h0010);
    step();
    chk("t1_read_c2", mem_read, 1);
    step();
    chk("t1_i_done", i_done, 1);
    chk("t1_i_rdata", i_rdata, 16'hABCD);
    chk("t1_d_done", d_done, 0);
    chk("t1_read_off", mem_read, 0);
    i_req = 1'b0;
    step();
    chk("t1_idle", busy, 0);

    // Lone store with address/data changing after grant
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    step();
    chk("t2_write_c1", mem_write, 1);
    chk("t2_addr_c1", mem_addr, 16'h0040);
    chk("t2_wdata_c1", mem_wdata, 16'h1234);
    d_addr = 16'h0099; d_wdata = 16'h5555;
    step();
    chk("t2_write_c2", mem_write, 1);
    chk("t2_addr_c2", mem_addr, 16'h0040);
    chk("t2_wdata_c2", mem_wdata, 16'h1234);
    step();
    chk("t2_d_done", d_done, 1);
    chk("t2_i_done", i_done, 0);
    chk("t2_write_off", mem_write, 0);
    d_req = 1'b0; d_we = 1'b0;
    step();

    // Both requesting continuously: four data grants then one fetch, twice
    i_req = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
    for (int k = 0; k < 10; k++) begin
      wait_done("t3_done", own);
      owners[k] = own;
      d_addr = 16'h0100 + 16'(k + 1);
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t3_owner%0d", k), owners[k], exp_owners[k]);
    end
    step();

    // Fetch withdrawn before its grant while a store is in flight
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0060; d_wdata = 16'h7777;
    rd_cnt = 0; idone_cnt = 0;
    step();
    i_req = 1'b1; i_addr = 16'h0300;
    step();
    step();
    chk("t4_d_done", d_done, 1);
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (mem_read) rd_cnt++;
      if (i_done) idone_cnt++;
    end
    chk("t4_no_fetch_read", rd_cnt, 0);
    chk("t4_no_i_done", idone_cnt, 0);

    // Reset in the middle of a write
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0050; d_wdata = 16'hBEEF;
    step();
    chk("t5_write_pre", mem_write, 1);
    #1;
    reset = 1'b1;
    d_req = 1'b0; d_we = 1'b0;
    #1;
    chk("t5_write_rst", mem_write, 0);
    chk("t5_busy_rst", busy, 0);
    chk("t5_d_done_rst", d_done, 0);
    chk("t5_i_done_rst", i_done, 0);
    chk("t5_addr_rst", mem_addr, 0);
    chk("t5_wdata_rst", mem_wdata, 0);
    step();
    reset = 1'b0;
    step();
    chk("t5_idle", busy, 0);
    i_req = 1'b1; i_addr = 16'h0010;
    lat = 0;
    while (!i_done && lat < 20) begin
      step();
      lat++;
      chk("t5_no_d_done", d_done, 0);
    end
    chk("t5_fetch_latency", lat, MEM_LAT + 1);
    chk("t5_i_rdata", i_rdata, 16'hABCD);
    i_req = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
